// File: rtl/calc_pkg.sv
// Shared calculator types: operand-stack command encodings, controller states
// and the word/address geometry of the Memory block.
package calc_pkg;

    localparam int CALC_DATA_W = 32;
    localparam int CALC_ADDR_W = 8;
    localparam int CALC_DEPTH  = 256;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } stack_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WRITE   = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_RESP    = 2'b11
    } stack_state_t;

endpackage

// File: rtl/rd_lat_counter.sv
// Counts down the Memory read latency; data_ready_o rises once RD_LAT cycles
// have elapsed since load_i while run_i was held.
module rd_lat_counter #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic data_ready_o
);

    logic [1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else if (load_i) begin
            cnt_q <= 2'(RD_LAT);
        end else if (run_i && (cnt_q != 2'd0)) begin
            cnt_q <= cnt_q - 2'd1;
        end
    end

    assign data_ready_o = (cnt_q == 2'd0);

endmodule

// File: rtl/operand_stack_ctrl.sv
// Operand stack controller: maps push/pop/peek/clear commands onto Memory
// write/read cycles and returns read words over a valid/ready response channel.
module operand_stack_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W = CALC_DATA_W,
    parameter int ADDR_W = CALC_ADDR_W,
    parameter int DEPTH  = CALC_DEPTH,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              err,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output stack_state_t      dbg_state_o
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    stack_state_t      state_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_we_q;
    logic              mem_oe_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              err_q;
    logic              pop_q;

    logic accept;
    logic is_read;
    logic lat_load;
    logic data_ready;

    // Commands are taken only in IDLE; reset holds the channel closed.
    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign is_read   = (cmd_op == OP_POP) || (cmd_op == OP_PEEK);
    assign lat_load  = accept && is_read && !empty;

    rd_lat_counter #(.RD_LAT(RD_LAT)) u_rd_lat (
        .clk          (clk),
        .rst          (reset),
        .load_i       (lat_load),
        .run_i        (state_q == ST_RD_WAIT),
        .data_ready_o (data_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_oe_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            err_q         <= 1'b0;
            pop_q         <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (stack_op_t'(cmd_op))
                            OP_PUSH: begin
                                if (full) begin
                                    err_q <= 1'b1;
                                end else begin
                                    state_q       <= ST_WRITE;
                                    mem_we_q      <= 1'b1;
                                    mem_address_q <= count_q[ADDR_W-1:0];
                                    mem_data_q    <= cmd_data;
                                end
                            end
                            OP_POP, OP_PEEK: begin
                                if (empty) begin
                                    err_q <= 1'b1;
                                end else begin
                                    state_q       <= ST_RD_WAIT;
                                    mem_oe_q      <= 1'b1;
                                    mem_address_q <= ADDR_W'(count_q - 1'b1);
                                    pop_q         <= (cmd_op == OP_POP);
                                end
                            end
                            default: count_q <= '0;
                        endcase
                    end
                end
                ST_WRITE: begin
                    mem_we_q      <= 1'b0;
                    mem_address_q <= '0;
                    mem_data_q    <= '0;
                    count_q       <= count_q + 1'b1;
                    state_q       <= ST_IDLE;
                end
                ST_RD_WAIT: begin
                    // oe and address stay put until the latency counter expires.
                    if (data_ready) begin
                        rsp_data_q    <= mem_rdata;
                        rsp_valid_q   <= 1'b1;
                        mem_oe_q      <= 1'b0;
                        mem_address_q <= '0;
                        if (pop_q) begin
                            count_q <= count_q - 1'b1;
                        end
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign count       = count_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;
    assign mem_oe      = mem_oe_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
